// File: rtl/dac_capture_pkg.sv
// dac_capture_pkg: capture FSM states, trigger-mode encodings and lane packing for the DAC capture buffer
package dac_capture_pkg;
   typedef enum logic [2:0] {IDLE, PRE, WAIT, POST, DONE} state_t;
   localparam logic [1:0] TRIG_EXT  = 2'd0;
   localparam logic [1:0] TRIG_LVL  = 2'd1;
   localparam logic [1:0] TRIG_IMM  = 2'd2;
   localparam logic [1:0] TRIG_NONE = 2'd3;
   // RAM words are packed {lane3, lane2, lane1, lane0}, lane0 in the LSBs
   localparam int LANES = 4;
endpackage

// File: rtl/dac_capture_buffer_ram.sv
// capture_ram: simple dual-port sample RAM, one write port, registered 1-cycle read, storage never reset
module capture_ram #(
   parameter int AW = 10,
   parameter int W  = 64
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [W-1:0]  wdata,
   input  logic          re,
   input  logic [AW-1:0] raddr,
   output logic [W-1:0]  rdata
);
   logic [W-1:0] mem [2**AW];
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      if (re) rdata <= mem[raddr];
   end
endmodule

// File: rtl/dac_capture_buffer.sv
// dac_capture_buffer: trigger-windowed capture of the 4-lane DAC FIFO stream into RAM with host readback
module dac_capture_buffer
   import dac_capture_pkg::*;
#(
   parameter int DW         = 16,
   parameter int DEPTH_LOG2 = 10,
   parameter int PRE_TRIG   = 64
) (
   input  logic                  rd_clk,
   input  logic                  rd_rst_n,
   input  logic                  in_valid,
   input  logic [DW-1:0]         in_data_0,
   input  logic [DW-1:0]         in_data_1,
   input  logic [DW-1:0]         in_data_2,
   input  logic [DW-1:0]         in_data_3,
   input  logic                  arm,
   input  logic [1:0]            trig_mode,
   input  logic                  trig_ext,
   input  logic [DW-1:0]         trig_thresh,
   input  logic                  rd_req,
   input  logic [DEPTH_LOG2-1:0] rd_addr,
   output logic                  rd_valid,
   output logic [4*DW-1:0]       rd_word,
   output logic                  busy,
   output logic                  done,
   output logic [DEPTH_LOG2-1:0] trig_pos,
   output logic [DEPTH_LOG2-1:0] start_addr
);
   localparam int AW = DEPTH_LOG2;
   localparam int DEPTH = 2**AW;
   localparam logic [AW-1:0] PRE_LAST = AW'(PRE_TRIG - 1);
   localparam logic [AW-1:0] PRE_OFS = AW'(PRE_TRIG);
   localparam logic [AW-1:0] REMAIN = AW'(DEPTH - PRE_TRIG - 1);
   localparam state_t ARM_STATE = (PRE_TRIG == 0) ? WAIT : PRE;
   state_t state_q, state_d;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d, cnt_q, cnt_d, trig_pos_q, trig_pos_d, start_q, start_d;
   logic signed [DW-1:0] prev_q, prev_d;
   logic prev_vld_q, prev_vld_d, rd_valid_q, rd_valid_d;
   logic capturing, we, lvl_hit, hit;
   logic [LANES*DW-1:0] ram_dout;
   assign capturing = state_q == PRE || state_q == WAIT || state_q == POST;
   // Mode 1 needs a previous valid sample since arm, so the first sample never fires
   assign lvl_hit = prev_vld_q && prev_q < $signed(trig_thresh) && $signed(in_data_0) >= $signed(trig_thresh);
   assign hit = trig_mode != TRIG_NONE &&
                ((trig_mode == TRIG_EXT && trig_ext) || (trig_mode == TRIG_LVL && lvl_hit) || trig_mode == TRIG_IMM);
   always_comb begin
      state_d = state_q;
      wr_ptr_d = wr_ptr_q;
      cnt_d = cnt_q;
      prev_d = prev_q;
      prev_vld_d = prev_vld_q;
      trig_pos_d = trig_pos_q;
      start_d = start_q;
      we = 1'b0;
      rd_valid_d = rd_req && !arm && (state_q == IDLE || state_q == DONE);
      if (arm) begin
         state_d = ARM_STATE;
         wr_ptr_d = '0;
         cnt_d = '0;
         prev_vld_d = 1'b0;
      end else if (in_valid && capturing) begin
         we = 1'b1;
         wr_ptr_d = wr_ptr_q + AW'(1);
         if (state_q != POST) begin
            prev_d = $signed(in_data_0);
            prev_vld_d = 1'b1;
         end
         if (state_q == PRE) begin
            cnt_d = cnt_q == PRE_LAST ? '0 : cnt_q + AW'(1);
            state_d = cnt_q == PRE_LAST ? WAIT : PRE;
         end else if (state_q == WAIT && hit) begin
            trig_pos_d = wr_ptr_q;
            start_d = wr_ptr_q - PRE_OFS;
            cnt_d = REMAIN;
            state_d = REMAIN == '0 ? DONE : POST;
         end else if (state_q == POST) begin
            cnt_d = cnt_q - AW'(1);
            state_d = cnt_q == AW'(1) ? DONE : POST;
         end
      end
   end
   always_ff @(posedge rd_clk or negedge rd_rst_n) begin
      if (!rd_rst_n) begin
         state_q <= IDLE;
         wr_ptr_q <= '0;
         cnt_q <= '0;
         prev_q <= '0;
         prev_vld_q <= 1'b0;
         trig_pos_q <= '0;
         start_q <= '0;
         rd_valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         wr_ptr_q <= wr_ptr_d;
         cnt_q <= cnt_d;
         prev_q <= prev_d;
         prev_vld_q <= prev_vld_d;
         trig_pos_q <= trig_pos_d;
         start_q <= start_d;
         rd_valid_q <= rd_valid_d;
      end
   end
   capture_ram #(.AW(AW), .W(LANES*DW)) u_ram (
      .clk  (rd_clk),
      .we   (we),
      .waddr(wr_ptr_q),
      .wdata({in_data_3, in_data_2, in_data_1, in_data_0}),
      .re   (rd_valid_d),
      .raddr(rd_addr),
      .rdata(ram_dout)
   );
   // The RAM read register has no reset, so data is masked to zero outside a valid beat
   assign rd_word = rd_valid_q ? ram_dout : '0;
   assign rd_valid = rd_valid_q;
   assign busy = capturing;
   assign done = state_q == DONE;
   assign trig_pos = trig_pos_q;
   assign start_addr = start_q;
endmodule
